// File: rtl/eh2_ifu_fetch_arb.sv
// ============================================================================
// Module   : eh2_ifu_fetch_arb
// Purpose  : Per-cycle F1 fetch-slot arbiter shared by the hardware threads.
//            Round robin with flush priority, miss deprioritization and an
//            optional starvation guard (enabled by RV_FETCH_ARB_STARVE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eh2_ifu_fetch_arb #(
  parameter int NUM_THREADS = 2,
  parameter int STARVE_MAX  = 15,
  parameter int STARVE_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] ifc_ready_t,
  input  logic [NUM_THREADS-1:0] exu_flush_final_t,
  input  logic [NUM_THREADS-1:0] ifu_ic_miss_f2_t,
  input  logic                   ic_busy,
  output logic                   ifc_select_tid_f1,
  output logic [NUM_THREADS-1:0] ifc_grant_f1,
  output logic [NUM_THREADS-1:0] pmu_fetch_arb_lost,
  output logic [NUM_THREADS-1:0] starve_force
);

  logic [NUM_THREADS-1:0] cand;
  assign cand = ifc_ready_t & {NUM_THREADS{~ic_busy}};

  if (NUM_THREADS < 1 || NUM_THREADS > 2 || (2 ** STARVE_W) <= STARVE_MAX) begin : g_bad_param
    $error("eh2_ifu_fetch_arb: illegal NUM_THREADS / STARVE_MAX / STARVE_W");
  end

  if (NUM_THREADS == 2) begin : g_mt
    logic       last_tid;
    logic [1:0] miss_dep;
    logic [1:0] sforce;
    logic [1:0] grant;
    logic       win;
    logic       any_grant;

`ifdef RV_FETCH_ARB_STARVE_EN
    for (genvar t = 0; t < 2; t++) begin : g_cnt
      logic [STARVE_W-1:0] cnt;
      assign sforce[t] = (cnt == STARVE_W'(STARVE_MAX));
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (!ic_busy) begin
          if (grant[t] || !ifc_ready_t[t]) begin
            cnt <= '0;
          end else if (!sforce[t]) begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
`else
    assign sforce = 2'b00;
`endif

    // Priority only matters when both threads compete; ties go to ~last_tid.
    always_comb begin
      win = ~last_tid;
      if (cand == 2'b01) begin
        win = 1'b0;
      end else if (cand == 2'b10) begin
        win = 1'b1;
      end else if (cand == 2'b11) begin
        if (sforce == 2'b11) begin
          win = ~last_tid;
        end else if (sforce != 2'b00) begin
          win = sforce[1];
        end else if (exu_flush_final_t == 2'b11) begin
          win = ~last_tid;
        end else if (exu_flush_final_t != 2'b00) begin
          win = exu_flush_final_t[1];
        end else if (miss_dep == 2'b11) begin
          win = ~last_tid;
        end else if (miss_dep != 2'b00) begin
          win = miss_dep[0];
        end else begin
          win = ~last_tid;
        end
      end
    end

    assign any_grant = |cand;
    assign grant     = any_grant ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign ifc_grant_f1       = rst ? 2'b00 : grant;
    assign ifc_select_tid_f1  = rst ? 1'b0 : (ic_busy ? last_tid : win);
    assign pmu_fetch_arb_lost = rst ? 2'b00 : (cand & ~grant);
    assign starve_force       = rst ? 2'b00 : sforce;

    // A new miss outranks a same-cycle grant or flush clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        last_tid <= 1'b1;
        miss_dep <= 2'b00;
      end else if (!ic_busy) begin
        if (any_grant) begin
          last_tid <= win;
        end
        miss_dep <= ifu_ic_miss_f2_t | (miss_dep & ~grant & ~exu_flush_final_t);
      end
    end
  end else begin : g_st
    assign ifc_grant_f1       = rst ? '0 : cand;
    assign ifc_select_tid_f1  = 1'b0;
    assign pmu_fetch_arb_lost = '0;
    assign starve_force       = '0;
  end

endmodule

`default_nettype wire
